// File: rtl/led_driver_pkg.sv
// led_driver_pkg: mode encodings, event-flash state type and queue limit shared by the LED driver
package led_driver_pkg;
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_EVENT = 2'b11;
    localparam logic [3:0] PEND_MAX   = 4'd15;
    typedef enum logic [1:0] {E_IDLE, E_ON, E_OFF} ev_state_e;
endpackage

// File: rtl/led_hold_timer.sv
// led_hold_timer: holds the LED level for at least HOLD_CYCLES before following a new target
module led_hold_timer #(
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic target_i,
    output logic lvl_o,
    output logic hold_ok_o
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          lvl_q, lvl_d;

    assign hold_ok_o = hold_cnt_q == HOLD_MAX;
    assign lvl_o     = lvl_q;

    // level may only move once the hold has elapsed; the age restarts on every change and saturates otherwise
    always_comb begin
        lvl_d      = hold_ok_o ? target_i : lvl_q;
        hold_cnt_d = (lvl_d != lvl_q) ? '0 : hold_ok_o ? hold_cnt_q : hold_cnt_q + 1'b1;
    end

    // level and age registers; reset leaves the hold satisfied so the first change is immediate
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q      <= 1'b0;
            hold_cnt_q <= HOLD_MAX;
        end else begin
            lvl_q      <= lvl_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end
endmodule

// File: rtl/led_driver.sv
// led_driver: off/on/blink/event-flash LED driver with a minimum hold time on every pin level
module led_driver
    import led_driver_pkg::*;
#(
    parameter int   HOLD_CYCLES = 1000000,
    parameter int   BLINK_HALF  = 12500000,
    parameter logic ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_i,
    input  logic       event_i,
    output logic       led_o,
    output logic       busy_o
);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    if (HOLD_CYCLES < 2 || BLINK_HALF < HOLD_CYCLES) begin : g_bad_params
        $error("led_driver: need HOLD_CYCLES >= 2 and BLINK_HALF >= HOLD_CYCLES");
    end

    logic [1:0]    mode_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d, blink_cnt_e;
    logic          blink_tgt_q, blink_tgt_d, blink_tgt_e;
    logic          enter_blink, blink_wrap, in_blink;
    ev_state_e     state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          is_ev, inc, enter_on;
    logic          target, lvl, hold_ok;

    // entering blink restarts the phase lit, and that restart already counts as phase position 0
    assign in_blink    = mode_i == MODE_BLINK;
    assign enter_blink = in_blink && mode_q != MODE_BLINK;
    assign blink_cnt_e = enter_blink ? '0 : blink_cnt_q;
    assign blink_tgt_e = enter_blink | blink_tgt_q;
    assign blink_wrap  = blink_cnt_e == BLINK_MAX;

    // blink phase counter advances only while blinking and flips the target at each wrap
    always_comb begin
        blink_cnt_d = !in_blink ? blink_cnt_q : blink_wrap ? '0 : blink_cnt_e + 1'b1;
        blink_tgt_d = !in_blink ? blink_tgt_q : blink_tgt_e ^ blink_wrap;
    end

    assign is_ev = mode_i == MODE_EVENT;

    // event-flash sequencing: lit phase, dark phase, then straight into the next queued flash
    always_comb begin
        state_d = state_q;
        if (!is_ev) begin
            state_d = E_IDLE;
        end else begin
            case (state_q)
                E_IDLE:  if (pend_q != 4'd0) state_d = E_ON;
                E_ON:    if (lvl && hold_ok) state_d = E_OFF;
                E_OFF:   if (!lvl && hold_ok) state_d = (pend_q != 4'd0) ? E_ON : E_IDLE;
                default: state_d = E_IDLE;
            endcase
        end
    end

    // queue of pending flashes, taken from on each entry to the lit phase
    always_comb begin
        inc      = is_ev && event_i && pend_q != PEND_MAX;
        enter_on = state_d == E_ON && state_q != E_ON;
        pend_d   = is_ev ? pend_q + 4'(inc) - 4'(enter_on) : 4'd0;
        busy_d   = is_ev && (state_d != E_IDLE || pend_d != 4'd0);
    end

    // a flash leaving idle lights one edge after entering E_ON; from E_OFF it lights on the entry edge itself
    assign target = (mode_i == MODE_OFF)   ? 1'b0 :
                    (mode_i == MODE_ON)    ? 1'b1 :
                    (mode_i == MODE_BLINK) ? blink_tgt_e :
                    (state_d == E_ON && state_q != E_IDLE);

    led_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .target_i (target),
        .lvl_o    (lvl),
        .hold_ok_o(hold_ok)
    );

    // mode history, blink phase, flash FSM, queue and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_OFF;
            blink_cnt_q <= '0;
            blink_tgt_q <= 1'b1;
            state_q     <= E_IDLE;
            pend_q      <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            mode_q      <= mode_i;
            blink_cnt_q <= blink_cnt_d;
            blink_tgt_q <= blink_tgt_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
        end
    end

    assign led_o  = lvl ^ ACTIVE_LOW;
    assign busy_o = busy_q;
endmodule
